// File: rtl/cube_pkg.sv
// Shared move-code definitions for the cube solver datapath (network, move_log, benches).
package cube_pkg;

  localparam int unsigned MOVE_W    = 4;
  localparam int unsigned NUM_MOVES = 12;

  typedef logic [MOVE_W-1:0] move_t;

  // Moves come in inverse pairs 0/1, 2/3, ... 10/11.
  function automatic move_t move_inv(input move_t k);
    return k ^ move_t'(1);
  endfunction

  function automatic logic move_legal(input move_t k);
    return k < move_t'(NUM_MOVES);
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Move storage FIFO: array, pointers and occupancy count.
// MOVE_LOG_CANCEL_EN adds a tail-retract port and tail read-out.
module move_fifo
  import cube_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
`ifdef MOVE_LOG_CANCEL_EN
  input  logic          retract,
  output move_t         tail_c,
`endif
  input  move_t         wdata,
  output move_t         rdata_c,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  move_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW-1:0]  wr_ptr_d, rd_ptr_d;
  logic [CW-1:0]  count_d;

  // Next pointer/count; clear dominates, retract replaces a push.
  always_comb begin
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    count_d  = count;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr + AW'(1);
      count_d = count + CW'(push) - CW'(pop);
`ifdef MOVE_LOG_CANCEL_EN
      if (retract) begin
        wr_ptr_d = wr_ptr - AW'(1);
        count_d  = count - CW'(1) - CW'(pop);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      count  <= count_d;
    end
  end

  // Storage is reset so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata_c = mem[rd_ptr];
`ifdef MOVE_LOG_CANCEL_EN
  assign tail_c  = mem[wr_ptr - AW'(1)];
`endif

endmodule

// File: rtl/move_log.sv
// Captures network move codes on the rising edge of net_valid into a FIFO with
// back-pressure via net_load. MOVE_LOG_CANCEL_EN enables inverse-pair cancellation.
module move_log
  import cube_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              net_valid,
  input  logic [MOVE_W-1:0] net_q,
  output logic              net_load,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [MOVE_W-1:0] m_data,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              bad_code
);

  logic  net_prev;
  logic  capture, legal, pop, full, push, drop;
  move_t head;
`ifdef MOVE_LOG_CANCEL_EN
  logic  cancel;
  move_t tail;
`endif

  assign m_valid = (count != '0);
  assign m_data  = head;

  // Capture/push decision for the current cycle.
  always_comb begin
    capture = net_valid && !net_prev;
    legal   = move_legal(net_q);
    pop     = m_valid && m_ready;
    full    = (count == CW'(DEPTH));
`ifdef MOVE_LOG_CANCEL_EN
    // Popping the only entry wins over cancelling it.
    cancel  = capture && legal && m_valid && (net_q == move_inv(tail))
              && !(pop && count == CW'(1));
    push    = capture && legal && !cancel && (!full || pop);
    drop    = capture && legal && !cancel && full && !pop;
`else
    push    = capture && legal && (!full || pop);
    drop    = capture && legal && full && !pop;
`endif
  end

  // Edge detector survives clear so a held level never re-captures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      net_prev <= 1'b0;
      overflow <= 1'b0;
      bad_code <= 1'b0;
      net_load <= 1'b0;
    end else begin
      net_prev <= net_valid;
      net_load <= (count <= CW'(DEPTH - 2)) && !clear;
      if (clear) begin
        overflow <= 1'b0;
        bad_code <= 1'b0;
      end else begin
        if (drop)               overflow <= 1'b1;
        if (capture && !legal)  bad_code <= 1'b1;
      end
    end
  end

  move_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .push    (push),
    .pop     (pop),
`ifdef MOVE_LOG_CANCEL_EN
    .retract (cancel),
    .tail_c  (tail),
`endif
    .wdata   (net_q),
    .rdata_c (head),
    .count   (count)
  );

endmodule

// File: tb/tb_move_log.sv
// Scoreboard bench for move_log: expected moves queued at stimulus time, popped by a monitor.
module tb_move_log;
  import cube_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n, clear, net_valid, m_ready;
  logic [3:0]    net_q;
  logic          net_load, m_valid, overflow, bad_code;
  logic [3:0]    m_data;
  logic [CW-1:0] count;

  int         errors = 0;
  int         checks = 0;
  int         pops_seen = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;

  always #5 clk = ~clk;

  move_log #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .net_valid (net_valid),
    .net_q     (net_q),
    .net_load  (net_load),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .count     (count),
    .overflow  (overflow),
    .bad_code  (bad_code)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] code);
    net_q     = code;
    net_valid = 1'b1;
    tick();
    net_valid = 1'b0;
    tick();
  endtask

  task automatic drain(input string name);
    m_ready = 1'b1;
    for (int i = 0; i < 64 && count != '0; i++) tick();
    m_ready = 1'b0;
    check({name, "_count"}, int'(count), 0);
    check({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  // Monitor: every accepted head entry must match the scoreboard front.
  always @(negedge clk) begin
    if (rst_n && !clear && m_valid && m_ready) begin
      pops_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0d expected no entry", m_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (m_data !== mon_exp) begin
          errors++;
          $display("FAIL pop_data: got %0d expected %0d", m_data, mon_exp);
        end
      end
    end
  end

  initial begin
    int p0;
    rst_n = 1'b0; clear = 1'b0; net_valid = 1'b0; net_q = '0; m_ready = 1'b1;
    repeat (3) tick();
    check("rst_count", int'(count), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_net_load", int'(net_load), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_bad_code", int'(bad_code), 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_net_load", int'(net_load), 1);
    check("post_rst_m_valid", int'(m_valid), 0);

    // Held level captures exactly once
    p0 = pops_seen;
    exp_q.push_back(4'h5);
    net_q = 4'h5; net_valid = 1'b1;
    repeat (50) tick();
    net_valid = 1'b0;
    tick();
    check("hold_one_entry", pops_seen - p0, 1);
    check("hold_count", int'(count), 0);

    // Fill past full with m_ready low
    m_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      logic [3:0] code;
      code = 4'((2 * (i - 1)) % 12);
      if (i <= 16) exp_q.push_back(code);
      pulse(code);
      if (i == 14) check("load_at_14", int'(net_load), 1);
      if (i == 15) check("load_at_15", int'(net_load), 0);
      if (i == 16) begin
        check("full_count", int'(count), 16);
        check("ovf_at_16", int'(overflow), 0);
      end
      if (i == 17) check("ovf_at_17", int'(overflow), 1);
    end
    check("fill_count", int'(count), 16);
    drain("fill_drain");

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_ovf", int'(overflow), 0);
    check("clear_load_low", int'(net_load), 0);
    tick();
    check("clear_load_back", int'(net_load), 1);

    // Push into a full FIFO alongside a pop
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(4'((2 * k) % 12));
      pulse(4'((2 * k) % 12));
    end
    check("refill_count", int'(count), 16);
    check("refill_ovf", int'(overflow), 0);
    check("refill_load", int'(net_load), 0);
    exp_q.push_back(4'h6);
    net_q = 4'h6; net_valid = 1'b1; m_ready = 1'b1;
    tick();
    m_ready = 1'b0; net_valid = 1'b0;
    tick();
    check("pushpop_count", int'(count), 16);
    check("pushpop_ovf", int'(overflow), 0);
    drain("pushpop_drain");

    // Illegal code sets bad_code; clear flushes
    pulse(4'h7);
    check("pre_bad_count", int'(count), 1);
    pulse(4'hC);
    check("bad_flag", int'(bad_code), 1);
    check("bad_count", int'(count), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("bad_cleared", int'(bad_code), 0);
    check("clear_count", int'(count), 0);

    // Inverse pair 3 then 2
    exp_q.push_back(4'h3);
    pulse(4'h3);
    check("inv_first_count", int'(count), 1);
`ifdef MOVE_LOG_CANCEL_EN
    void'(exp_q.pop_back());
    pulse(4'h2);
    check("inv_cancel_count", int'(count), 0);
`else
    exp_q.push_back(4'h2);
    pulse(4'h2);
    check("inv_keep_count", int'(count), 2);
`endif
    drain("inv_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/move_log.md
Name: move_log

Overview:
- Downstream consumer of `network`. Captures each 4-bit move code `q` that the network produces when its `valid` asserts, and stores it in a FIFO.
- Presents stored moves to the host/output side with a valid/ready handshake.
- Back-pressures the network through its `load` input, so a new inference is never started without buffer space to hold the result.

Parameters:
- DEPTH, 16, number of move entries stored; power of two, 4..64.
- CW, $clog2(DEPTH)+1, occupancy counter width (derived; not overridden).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush of FIFO and flags
- net_valid  input  1  network `valid`; a level that stays high while the result is held
- net_q  input  4  network `q` move code
- net_load  output  1  drives network `load`
- m_valid  output  1  head entry available
- m_ready  input  1  consumer accepts head entry
- m_data  output  4  head move code
- count  output  CW  current occupancy
- overflow  output  1  sticky: a capture was lost because the FIFO was full
- bad_code  output  1  sticky: a code in 12..15 was received

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty, pointers 0, count=0.
  - m_valid=0, m_data=0, net_load=0, overflow=0, bad_code=0.
  - net_valid edge detector cleared to 0.
- Move encoding:
  - 0..11 are legal; move k and k^1 are mutual inverses (pairs 0/1, 2/3, ... 10/11).
  - 12..15 are illegal: never stored, and set bad_code.
- Capture:
  - Rising edge of net_valid only (registered previous value; the capture cycle is when net_valid=1 and prev=0).
  - A level held high for many cycles yields exactly one entry.
- Write:
  - On a capture cycle with a legal code and count<DEPTH (accounting for a same-cycle pop), store net_q at wr_ptr and increment wr_ptr modulo DEPTH.
  - If full and no same-cycle pop, drop the code and set overflow.
- Read:
  - m_valid = (count!=0). m_data is the head entry, combinational from the storage array.
  - A pop occurs when m_valid && m_ready; rd_ptr increments modulo DEPTH.
- Simultaneous push and pop:
  - count unchanged.
  - A push into a full FIFO is accepted when a pop occurs in the same cycle.
  - Push into an empty FIFO: the entry appears with m_valid=1 on the next cycle; there is no fall-through.
- Pointers wrap naturally at DEPTH; full/empty are derived from count.
- net_load:
  - Registered. Equals 1 when count <= DEPTH-2 and clear=0.
  - This reserves one slot for an in-flight result.
  - Drops to 0 in the cycle after count reaches DEPTH-1.
- clear:
  - Has priority over push and pop in the same cycle.
  - Empties the FIFO and zeroes overflow and bad_code.
  - The edge detector is kept, so a held net_valid does not re-capture.
- Reset mid-operation:
  - All contents are lost.
  - After release, net_load rises on the first clock edge.
- Latency: capture edge -> m_valid high is 1 cycle.

Optional Feature:
- MOVE_LOG_CANCEL_EN defined:
  - If the captured legal code equals tail^1 (the most recently written entry still in the FIFO, count>=1), the tail is removed instead of pushing. wr_ptr decrements and count decrements.
  - If a pop of that same single entry happens in the same cycle, the pop wins and the new code is pushed normally.
- Undefined: every legal code is pushed; no tail tracking logic is present.

Decomposition:
- Package `cube_pkg`:
  - MOVE_W=4, NUM_MOVES=12.
  - Function for a move's inverse (k^1).
  - Function for legality (k<12).
  - Shared with `network` and its testbench.
- Sub-module `move_fifo`: storage array, pointers, count, and the optional tail-retract port.
- `move_log` wraps `move_fifo` with edge detection, legality check, flags and net_load.

Test Plan:
- Reset then idle, m_ready=1:
  - m_valid=0, count=0, net_load=1 one cycle after rst_n rises.
- net_valid held high for 50 cycles with net_q=4'h5:
  - exactly one entry; m_data=5 for one cycle; count returns to 0.
- DEPTH=16, m_ready=0, 20 pulsed captures of codes 0,2,4,... (mod 12):
  - net_load falls once count=15.
  - 16 entries stored in order; overflow=1 after the 17th.
  - Draining returns the codes in FIFO order.
- Full FIFO, capture of code 6 in the same cycle as a pop:
  - count stays 16, overflow stays 0, and 6 is the last entry drained.
- Capture of 4'hC:
  - bad_code=1, count unchanged.
  - A following clear gives bad_code=0 and count=0.
- With MOVE_LOG_CANCEL_EN, captures 3 then 2 with m_ready=0:
  - count goes 1 then 0.
  - Without the macro, count=2 and the drain order is 3, 2.
